// File: rtl/memory_access_arbiter_pkg.sv
// Shared encodings and defaults for the memory access arbiter.
// Arbiter FSM states, bus access direction codes, enable levels and default parameters.
package memory_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_BUSY_FETCH = 2'd1,
        ARB_BUSY_DATA  = 2'd2
    } arb_state_e;

    // Bus access direction
    localparam logic READ    = 1'b0;
    localparam logic WRITE   = 1'b1;

    // Enable levels
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Fetches always read the full word
    localparam logic [3:0] FULL_WORD_MASK = 4'b1111;

    localparam int DEF_STARVE_LIMIT   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/memory_arbiter_priority.sv
// Combinational winner select between fetch and LSU requests.
// The LSU wins ties, except when fetch has been passed over STARVE_LIMIT times.
module memory_arbiter_priority (
    input  logic fetch_request_i,
    input  logic data_request_i,
    input  logic starve_hit_i,
    output logic fetch_grant_o,
    output logic data_grant_o
);

    assign fetch_grant_o = fetch_request_i & (~data_request_i | starve_hit_i);
    assign data_grant_o  = data_request_i & ~(fetch_request_i & starve_hit_i);

endmodule

// File: rtl/memory_access_arbiter.sv
// Memory access arbiter: shares one single-port memory bus between the instruction
// fetch and the load/store unit. The winning request is registered, held on the bus
// until memory_ready, and answered with a one-cycle valid pulse.
// Optional macro MEMORY_TIMEOUT_EN adds a wait-state timeout that aborts the access.
module memory_access_arbiter
    import memory_access_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`ifdef MEMORY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        fetch_request,
    input  logic [31:0] fetch_address,
    output logic        fetch_grant,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,

    input  logic        data_request,
    input  logic        data_state,
    input  logic [31:0] data_address,
    input  logic [3:0]  data_frame_mask,
    input  logic [31:0] data_write_data,
    output logic        data_grant,
    output logic        data_valid,
    output logic [31:0] data_read_data,

    output logic        memory_enable,
    output logic        memory_state,
    output logic [31:0] memory_address,
    output logic [3:0]  memory_frame_mask,
    output logic [31:0] memory_write_data,
    input  logic [31:0] memory_read_data,
    input  logic        memory_ready,
    output logic        memory_timeout
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e          state_q;
    logic [STARVE_W-1:0] starve_count_q;
    logic                starve_hit;
    logic                idle;
    logic                abort;

    logic        fetch_valid_q;
    logic [31:0] fetch_data_q;
    logic        data_valid_q;
    logic [31:0] data_read_data_q;
    logic        memory_enable_q;
    logic        memory_state_q;
    logic [31:0] memory_address_q;
    logic [3:0]  memory_frame_mask_q;
    logic [31:0] memory_write_data_q;

    // Byte offset bits never reach the word-addressed bus
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_address[1:0], data_address[1:0]};

    assign idle       = (state_q == ARB_IDLE);
    assign starve_hit = (starve_count_q == STARVE_W'(STARVE_LIMIT));

    // Requests are only considered while idle, so grants never appear mid-access
    memory_arbiter_priority u_priority (
        .fetch_request_i (fetch_request & idle),
        .data_request_i  (data_request & idle),
        .starve_hit_i    (starve_hit),
        .fetch_grant_o   (fetch_grant),
        .data_grant_o    (data_grant)
    );

`ifdef MEMORY_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_count_q;
    logic              memory_timeout_q;

    // Abort on the last tolerated wait state; a ready on that same cycle still completes
    assign abort = !idle && !memory_ready && (wait_count_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Count wait states of the current access; restarts from zero on every new access
    always_ff @(posedge clk) begin
        if (!reset || idle) begin
            wait_count_q <= '0;
        end else if (!memory_ready) begin
            wait_count_q <= wait_count_q + 1'b1;
        end
    end

    // Timeout pulse lines up with the owner's valid pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            memory_timeout_q <= 1'b0;
        end else begin
            memory_timeout_q <= abort;
        end
    end

    assign memory_timeout = memory_timeout_q;
`else
    assign abort          = 1'b0;
    assign memory_timeout = 1'b0;
`endif

    // Arbitration FSM: grant in IDLE, hold the registered access until ready, then respond
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q             <= ARB_IDLE;
            starve_count_q      <= '0;
            fetch_valid_q       <= 1'b0;
            fetch_data_q        <= '0;
            data_valid_q        <= 1'b0;
            data_read_data_q    <= '0;
            memory_enable_q     <= DISABLE;
            memory_state_q      <= READ;
            memory_address_q    <= '0;
            memory_frame_mask_q <= '0;
            memory_write_data_q <= '0;
        end else begin
            fetch_valid_q    <= 1'b0;
            fetch_data_q     <= '0;
            data_valid_q     <= 1'b0;
            data_read_data_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (fetch_grant) begin
                        state_q             <= ARB_BUSY_FETCH;
                        starve_count_q      <= '0;
                        memory_enable_q     <= ENABLE;
                        memory_state_q      <= READ;
                        memory_address_q    <= {fetch_address[31:2], 2'b00};
                        memory_frame_mask_q <= FULL_WORD_MASK;
                        memory_write_data_q <= '0;
                    end else if (data_grant) begin
                        state_q             <= ARB_BUSY_DATA;
                        if (fetch_request && !starve_hit) begin
                            starve_count_q <= starve_count_q + 1'b1;
                        end
                        memory_enable_q     <= ENABLE;
                        memory_state_q      <= data_state;
                        memory_address_q    <= {data_address[31:2], 2'b00};
                        memory_frame_mask_q <= data_frame_mask;
                        memory_write_data_q <= (data_state == WRITE) ? data_write_data : '0;
                    end
                end
                ARB_BUSY_FETCH, ARB_BUSY_DATA: begin
                    if (memory_ready || abort) begin
                        state_q             <= ARB_IDLE;
                        memory_enable_q     <= DISABLE;
                        memory_state_q      <= READ;
                        memory_address_q    <= '0;
                        memory_frame_mask_q <= '0;
                        memory_write_data_q <= '0;
                        if (state_q == ARB_BUSY_FETCH) begin
                            fetch_valid_q <= 1'b1;
                            fetch_data_q  <= memory_ready ? memory_read_data : '0;
                        end else begin
                            data_valid_q     <= 1'b1;
                            data_read_data_q <= (memory_ready && memory_state_q == READ)
                                                ? memory_read_data : '0;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign fetch_valid       = fetch_valid_q;
    assign fetch_data        = fetch_data_q;
    assign data_valid        = data_valid_q;
    assign data_read_data    = data_read_data_q;
    assign memory_enable     = memory_enable_q;
    assign memory_state      = memory_state_q;
    assign memory_address    = memory_address_q;
    assign memory_frame_mask = memory_frame_mask_q;
    assign memory_write_data = memory_write_data_q;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Self-checking bench for memory_access_arbiter: a scoreboard queues the expected
// response at each grant and compares it when fetch_valid/data_valid pulses.
// Define MEMORY_TIMEOUT_EN to exercise the timeout variant (TIMEOUT_CYCLES=8).
module tb_memory_access_arbiter;

    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        fetch_grant;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        data_request;
    logic        data_state;
    logic [31:0] data_address;
    logic [3:0]  data_frame_mask;
    logic [31:0] data_write_data;
    logic        data_grant;
    logic        data_valid;
    logic [31:0] data_read_data;
    logic        memory_enable;
    logic        memory_state;
    logic [31:0] memory_address;
    logic [3:0]  memory_frame_mask;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;
    logic        memory_ready;
    logic        memory_timeout;

    always #5 clk = ~clk;

    memory_access_arbiter #(
        .STARVE_LIMIT(4)
`ifdef MEMORY_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TB_TIMEOUT)
`endif
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_request     (fetch_request),
        .fetch_address     (fetch_address),
        .fetch_grant       (fetch_grant),
        .fetch_valid       (fetch_valid),
        .fetch_data        (fetch_data),
        .data_request      (data_request),
        .data_state        (data_state),
        .data_address      (data_address),
        .data_frame_mask   (data_frame_mask),
        .data_write_data   (data_write_data),
        .data_grant        (data_grant),
        .data_valid        (data_valid),
        .data_read_data    (data_read_data),
        .memory_enable     (memory_enable),
        .memory_state      (memory_state),
        .memory_address    (memory_address),
        .memory_frame_mask (memory_frame_mask),
        .memory_write_data (memory_write_data),
        .memory_read_data  (memory_read_data),
        .memory_ready      (memory_ready),
        .memory_timeout    (memory_timeout)
    );

    typedef struct {
        logic        is_fetch;
        logic [31:0] data;
        logic        tmo;
        int          cyc;
    } resp_t;

    resp_t sb_q[$];
    logic  grant_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Memory model and expectation controls
    int          mem_wait       = 0;
    int          busy_cnt       = 0;
    int          last_busy_len  = 0;
    logic [31:0] rd_key         = 32'h0;
    logic        idle_noise     = 1'b0;
    logic        expect_timeout = 1'b0;
    logic        mon_en         = 1'b0;
    logic [31:0] last_fetch_data = 32'h0;

    // Expected bus fields of the access in flight
    logic [31:0] bus_addr  = 32'h0;
    logic        bus_state = 1'b0;
    logic [3:0]  bus_mask  = 4'h0;
    logic [31:0] bus_wdata = 32'h0;

    assign memory_read_data = memory_enable ? (memory_address ^ rd_key) : 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, scoreboard and memory model, all sampled on the falling edge
    always @(negedge clk) begin
        resp_t e;
        if (mon_en) begin
            if (fetch_request && data_request)
                check_eq("single_grant", 32'(fetch_grant & data_grant), 32'h0);
            if (fetch_grant || data_grant) begin
                e.tmo = expect_timeout;
                e.cyc = cyc + (expect_timeout ? (1 + TB_TIMEOUT) : (2 + mem_wait));
                if (fetch_grant) begin
                    e.is_fetch = 1'b1;
                    bus_addr   = {fetch_address[31:2], 2'b00};
                    bus_state  = 1'b0;
                    bus_mask   = 4'hF;
                    bus_wdata  = 32'h0;
                    e.data     = expect_timeout ? 32'h0 : (bus_addr ^ rd_key);
                end else begin
                    e.is_fetch = 1'b0;
                    bus_addr   = {data_address[31:2], 2'b00};
                    bus_state  = data_state;
                    bus_mask   = data_frame_mask;
                    bus_wdata  = data_state ? data_write_data : 32'h0;
                    e.data     = (expect_timeout || data_state) ? 32'h0 : (bus_addr ^ rd_key);
                end
                sb_q.push_back(e);
                grant_log.push_back(fetch_grant);
            end
            if (memory_enable) begin
                check_eq("bus_addr",  memory_address, bus_addr);
                check_eq("bus_state", 32'(memory_state), 32'(bus_state));
                check_eq("bus_mask",  32'(memory_frame_mask), 32'(bus_mask));
                check_eq("bus_wdata", memory_write_data, bus_wdata);
            end else begin
                check_eq("bus_idle_zero",
                         memory_address | memory_write_data | 32'(memory_frame_mask) | 32'(memory_state),
                         32'h0);
            end
            if (fetch_valid || data_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_valid", 32'(fetch_valid | data_valid), 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("dual_valid", 32'(fetch_valid & data_valid), 32'h0);
                    check_eq("owner", 32'(fetch_valid), 32'(e.is_fetch));
                    check_eq("resp_data", e.is_fetch ? fetch_data : data_read_data, e.data);
                    check_eq("timeout_flag", 32'(memory_timeout), 32'(e.tmo));
                    check_eq("latency", 32'(cyc), 32'(e.cyc));
                    if (fetch_valid) last_fetch_data = fetch_data;
                    $display("TXN %s data=%h timeout=%0b cycle=%0d",
                             fetch_valid ? "fetch" : "data ",
                             fetch_valid ? fetch_data : data_read_data, memory_timeout, cyc);
                end
            end else if (memory_timeout) begin
                check_eq("stray_timeout", 32'(memory_timeout), 32'h0);
            end
        end
        // Memory model: ready after mem_wait wait states; optional noise while idle
        if (memory_enable) begin
            memory_ready = (busy_cnt == mem_wait);
            busy_cnt++;
        end else begin
            if (busy_cnt != 0) last_busy_len = busy_cnt;
            busy_cnt = 0;
            memory_ready = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic issue(input logic is_f, input logic st, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] wd);
        int n;
        logic g;
        @(posedge clk); #1;
        if (is_f) begin
            fetch_request = 1'b1;
            fetch_address = a;
        end else begin
            data_request    = 1'b1;
            data_state      = st;
            data_address    = a;
            data_frame_mask = m;
            data_write_data = wd;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            g = is_f ? fetch_grant : data_grant;
        end while (!g && n < 50);
        check_eq(is_f ? "fetch_grant" : "data_grant", 32'(g), 32'h1);
        @(posedge clk); #1;
        fetch_request = 1'b0;
        data_request  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(sb_q.size()), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset           = 1'b0;
        fetch_request   = 1'b0;
        fetch_address   = 32'h0;
        data_request    = 1'b0;
        data_state      = 1'b0;
        data_address    = 32'h0;
        data_frame_mask = 4'h0;
        data_write_data = 32'h0;
        memory_ready    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        check_eq("rst_data_valid",  32'(data_valid), 32'h0);
        check_eq("rst_enable",      32'(memory_enable), 32'h0);
        check_eq("rst_state",       32'(memory_state), 32'h0);
        check_eq("rst_addr",        memory_address, 32'h0);
        check_eq("rst_timeout",     32'(memory_timeout), 32'h0);
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        // Fetch only, unaligned address, ready on first busy cycle
        mem_wait = 0;
        rd_key   = 32'hDEADBEEF ^ 32'h0000_1004;
        issue(1'b1, 1'b0, 32'h0000_1006, 4'h0, 32'h0);
        drain();
        check_eq("fetch_deadbeef", last_fetch_data, 32'hDEADBEEF);

        // Data write with three wait states
        mem_wait = 3;
        issue(1'b0, 1'b1, 32'h0000_0020, 4'b0011, 32'hAB12_0000);
        drain();
        check_eq("write_busy_len", 32'(last_busy_len), 32'd4);

        // Mixed single transactions, ready noise while idle
        idle_noise = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_wait = $urandom_range(0, 3);
            rd_key   = $urandom;
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  4'($urandom_range(0, 15)), $urandom);
            drain();
        end
        idle_noise = 1'b0;

        // Both requesting continuously: data x4, fetch x1
        mem_wait = 0;
        grant_log.delete();
        @(posedge clk); #1;
        fetch_request   = 1'b1;
        fetch_address   = 32'h0000_2000;
        data_request    = 1'b1;
        data_state      = 1'b0;
        data_address    = 32'h0000_3008;
        data_frame_mask = 4'hF;
        data_write_data = 32'h0;
        n = 0;
        while (grant_log.size() < 15 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        fetch_request = 1'b0;
        data_request  = 1'b0;
        check_eq("starve_grants", 32'(grant_log.size()), 32'd15);
        for (int i = 0; i < 15 && i < grant_log.size(); i++)
            check_eq("starve_seq", 32'(grant_log[i]), 32'((i % 5) == 4));
        drain();

        // Reset while a data read is waiting
        mem_wait = 100000;
        issue(1'b0, 1'b0, 32'h0000_0080, 4'hF, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_enable",     32'(memory_enable), 32'h0);
        check_eq("midrst_data_valid", 32'(data_valid), 32'h0);
        check_eq("midrst_addr",       memory_address, 32'h0);
        check_eq("midrst_mask",       32'(memory_frame_mask), 32'h0);
        @(posedge clk); #1;
        reset    = 1'b1;
        mem_wait = 0;
        repeat (2) @(negedge clk);
        check_eq("midrst_no_valid", 32'(sb_q.size()), 32'h0);
        issue(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0);
        drain();

`ifdef MEMORY_TIMEOUT_EN
        // Ready never arrives: abort after TIMEOUT_CYCLES busy cycles
        expect_timeout = 1'b1;
        mem_wait       = 100000;
        issue(1'b0, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
        drain();
        // Ready on the boundary cycle completes normally
        expect_timeout = 1'b0;
        mem_wait       = TB_TIMEOUT - 1;
        issue(1'b0, 1'b0, 32'h0000_0044, 4'hF, 32'h0);
        drain();
`else
        // Long wait completes normally; nothing times out
        mem_wait = 300;
        issue(1'b0, 1'b0, 32'h0000_0048, 4'hF, 32'h0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access_arbiter.md
Name: memory_access_arbiter

Overview:
- Shares the single-port data memory interface between the instruction fetch requester and the load/store unit requester.
- Arbitrates between them, registers the winning request, holds it on the memory bus until memory_ready, then returns a one-cycle response to the winner.
- Sits between the fetch and LSU stages and the memory wrapper. Drives explicit read/write data buses, not a bidirectional bus.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced to win one arbitration.
- TIMEOUT_CYCLES, 255: wait-state cycles tolerated before abort. Used only with MEMORY_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- fetch_request  in  1  fetch wants a word read
- fetch_address  in  32  fetch byte address; bits [1:0] ignored
- fetch_grant  out  1  request accepted this cycle (combinational, IDLE only)
- fetch_valid  out  1  one-cycle response pulse
- fetch_data  out  32  read word, valid with fetch_valid
- data_request  in  1  LSU wants an access
- data_state  in  1  `READ` / `WRITE` (Defines.v encodings)
- data_address  in  32  byte address; bits [1:0] dropped on the bus
- data_frame_mask  in  4  byte-lane mask, passed through unchanged
- data_write_data  in  32  lane-positioned store data
- data_grant  out  1  request accepted this cycle
- data_valid  out  1  one-cycle completion pulse (reads and writes)
- data_read_data  out  32  read word; 0 for writes
- memory_enable  out  1  bus transaction active
- memory_state  out  1  `READ` / `WRITE`
- memory_address  out  32  word-aligned address {addr[31:2],2'b00}
- memory_frame_mask  out  4  lane mask; 4'b1111 for fetch
- memory_write_data  out  32  store data; 0 for reads
- memory_read_data  in  32  memory read word
- memory_ready  in  1  memory completes the current access this cycle
- memory_timeout  out  1  one-cycle abort pulse; constant 0 without the macro

Behaviour:
- States: IDLE, BUSY_FETCH, BUSY_DATA.
- Reset (reset==0 at an edge):
  - go to IDLE; starve_count=0.
  - All outputs 0; memory_state=`READ`.
  - Any in-flight access is dropped with no valid pulse. Applies mid-transaction too.
- IDLE arbitration:
  - data_request only: data wins.
  - fetch_request only: fetch wins.
  - Both requests: data wins, unless starve_count==STARVE_LIMIT, then fetch wins.
  - The winner's grant is asserted combinationally. Its fields are registered at that edge, and the state moves to the matching BUSY state.
  - At most one grant per cycle. No grant outside IDLE.
- starve_count:
  - increments, saturating, on each data grant issued while fetch_request=1.
  - clears on any fetch grant.
- BUSY states:
  - memory_enable=1; address, state, mask and write data come from registers and are stable until completion.
  - When memory_ready=1: capture memory_read_data (write: 0), go to IDLE, and pulse the winner's valid for exactly one cycle on the next cycle.
- Latency:
  - grant at cycle 0, memory_enable from cycle 1.
  - If ready arrives at cycle 1, valid is at cycle 2. Each wait state adds 1.
  - The valid cycle is an IDLE cycle, so a new grant may coincide with it. Minimum spacing between grants is 2 cycles.
- Requester rules:
  - Hold request and fields stable until grant.
  - Withdrawing before grant is legal; no transaction results.
  - The arbiter ignores requester fields after grant.
- When not busy, memory_* outputs are driven to 0, never Z.
- memory_ready seen in IDLE is ignored.

Optional Feature:
- Macro: MEMORY_TIMEOUT_EN.
- Enabled:
  - a wait counter clears on entry to each BUSY state and increments each cycle ready=0.
  - When it reaches TIMEOUT_CYCLES with ready still 0: go to IDLE, pulse the owner's valid with data 0, and pulse memory_timeout in the same cycle.
  - Ready arriving on the boundary cycle wins over timeout.
- Disabled: BUSY waits indefinitely; memory_timeout tied 0; no counter logic.

Decomposition:
- Defines.v (shared):
  - state encodings ARB_IDLE/ARB_BUSY_FETCH/ARB_BUSY_DATA;
  - `READ`/`WRITE`/`ENABLE`/`DISABLE`;
  - default STARVE_LIMIT and TIMEOUT_CYCLES.
- One natural sub-module, memory_arbiter_priority:
  - pure combinational winner select from the two requests and the starve_count==STARVE_LIMIT flag;
  - outputs fetch_grant/data_grant.
- FSM and registers stay in the top module.

Test Plan:
- Fetch only, address 0x0000_1006, ready at first BUSY cycle, memory_read_data 0xDEADBEEF:
  - fetch_grant at cycle 0;
  - memory_address 0x0000_1004, mask 4'b1111 at cycle 1;
  - fetch_valid with 0xDEADBEEF at cycle 2.
- Data write, address 0x20, mask 4'b0011, wdata 0xAB120000, ready after 3 wait states:
  - bus fields stable for 4 cycles;
  - data_valid once, data_read_data 0.
- Both requesting continuously, STARVE_LIMIT=4:
  - grants follow data×4, fetch×1, repeating;
  - no cycle has both grants.
- Reset asserted in BUSY_DATA with ready=0:
  - next cycle all outputs 0 and state IDLE;
  - no data_valid;
  - a subsequent fetch gets a normal grant.
- MEMORY_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready held 0:
  - memory_timeout and data_valid pulse together with data 0 after 8 BUSY cycles.
  - A repeat run with ready=1 on the 8th cycle completes normally with no timeout.
